// File: rtl/wwd_output_port.sv
// WWD output-port receiver: buffers each committed WWD word in a small FIFO
// and drains it to a host over valid/ready, with stall and sticky overflow flags.
module wwd_output_port #(
    parameter int WORD_BITS = 16,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 open_port,
    input  logic                 inst_commit,
    input  logic [WORD_BITS-1:0] port_data,
    output logic                 stall_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic [WORD_BITS-1:0] last_word,
    output logic [ADDR_BITS:0]   level,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS + 1)'(DEPTH);

    logic [WORD_BITS-1:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [WORD_BITS-1:0] last_word_q, last_word_d;

    logic wr, rd, full, push, drop;

    always_comb begin
        wr   = open_port & inst_commit;
        full = (level_q == FULL_LVL);
        rd   = (level_q != '0) & out_ready;
        // A write into a full FIFO is accepted only if the same edge pops the head.
        push = wr & (~full | rd);
        drop = wr & full & ~rd;

        rd_ptr_d = rd   ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;

        level_d = level_q;
        case ({push, rd})
            2'b10:   level_d = level_q + (ADDR_BITS + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_BITS + 1)'(1);
            default: level_d = level_q;
        endcase

        // A new drop beats a simultaneous clear.
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;

        last_word_d = wr ? port_data : last_word_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            last_word_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            last_word_q <= last_word_d;
        end
    end

    // Storage is never exposed while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= port_data;
    end

    always_comb begin
        out_valid = (level_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        stall_req = full;
        level     = level_q;
        overflow  = overflow_q;
        last_word = last_word_q;
    end

endmodule

// File: tb/tb_wwd_output_port.sv
// Directed bench for wwd_output_port: a queue scoreboard tracks accepted words
// and a small occupancy/flag model predicts level, stall, overflow and last_word.
module tb_wwd_output_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        open_port, inst_commit, out_ready, clr_overflow;
    logic [15:0] port_data;
    logic        stall_req, out_valid, overflow;
    logic [15:0] out_data, last_word;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb[$];
    int          mlevel = 0;
    logic        movf   = 1'b0;
    logic [15:0] mlast  = 16'h0;

    always #5 clk = ~clk;

    wwd_output_port #(.WORD_BITS(16), .DEPTH(4), .ADDR_BITS(2)) dut (
        .clk(clk), .reset_n(reset_n), .open_port(open_port), .inst_commit(inst_commit),
        .port_data(port_data), .stall_req(stall_req), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .last_word(last_word),
        .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check registered
    // outputs against the model, then advance the model for the coming edge.
    task automatic cyc(input logic op, input logic ic, input logic [15:0] d,
                       input logic rdy, input logic clr);
        logic rd, wr;
        @(negedge clk);
        open_port = op; inst_commit = ic; port_data = d; out_ready = rdy; clr_overflow = clr;
        #1;
        chk("out_valid", out_valid, mlevel != 0);
        chk("out_data", out_data, (mlevel != 0) ? sb[0] : 16'h0);
        chk("level", level, mlevel);
        chk("stall_req", stall_req, mlevel == 4);
        chk("overflow", overflow, movf);
        chk("last_word", last_word, mlast);
        rd = (mlevel != 0) && rdy;
        wr = op && ic;
        if (rd) begin
            void'(sb.pop_front());
            mlevel--;
        end
        if (wr) begin
            mlast = d;
            if (mlevel < 4) begin
                sb.push_back(d);
                mlevel++;
            end
        end
    endtask

    task automatic drain();
        repeat (7) cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        sb.delete();
        mlevel = 0;
        movf   = 1'b0;
        mlast  = 16'h0;
    endtask

    // Write that the model classifies (accept/drop) before the edge.
    task automatic wwd(input logic [15:0] d, input logic rdy, input logic clr);
        logic drop;
        drop = (mlevel == 4) && !rdy;
        cyc(1'b1, 1'b1, d, rdy, clr);
        if (drop)
            movf = 1'b1;
        else if (clr)
            movf = 1'b0;
    endtask

    task automatic idle(input logic rdy, input logic clr);
        cyc(1'b0, 1'b0, 16'h0, rdy, clr);
        if (clr) movf = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; open_port = 1'b0; inst_commit = 1'b0; port_data = 16'h0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state and a single WWD
        idle(1'b0, 1'b0);
        wwd(16'h1234, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        drain();

        // Fill, stall, drop with overflow, then drain 1..4 only
        for (int i = 1; i <= 4; i++) wwd(16'(i), 1'b0, 1'b0);
        wwd(16'h0005, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        drain();
        idle(1'b0, 1'b1);

        // Push and pop at full
        for (int i = 1; i <= 4; i++) wwd(16'(i), 1'b0, 1'b0);
        wwd(16'h0009, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        drain();

        // Gated write: open_port without commit does nothing
        repeat (3) cyc(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0);
        wwd(16'hBEEF, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        drain();

        // Backpressure and wrap: CPU holds its WWD while stall is seen
        begin
            int sent = 0;
            int cyc_n = 0;
            while (sent < 12 && cyc_n < 200) begin
                logic rdy;
                rdy = (cyc_n % 2) == 0;
                if (mlevel < 4) begin
                    wwd(16'h0100 + 16'(sent), rdy, 1'b0);
                    sent++;
                end else begin
                    idle(rdy, 1'b0);
                end
                cyc_n++;
            end
            chk("wrap_sent", sent, 12);
        end
        drain();

        // Async reset mid-drain at level 3
        for (int i = 0; i < 3; i++) wwd(16'h0A00 + 16'(i), 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_data", out_data, 16'h0);
        model_reset();
        @(negedge clk) reset_n = 1'b1;

        // Async reset while full drops stall immediately
        for (int i = 0; i < 4; i++) wwd(16'h0B00 + 16'(i), 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_level_full", level, 3'd0);
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        wwd(16'h00AA, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        drain();

        // Clear and drop in the same cycle: set wins
        for (int i = 1; i <= 4; i++) wwd(16'h0C00 + 16'(i), 1'b0, 1'b0);
        wwd(16'h0007, 1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
